// File: rtl/xadc_drp_sampler_if.sv
// DRP bus between the sampler (master) and the XADC primitive (slave).
interface xadc_drp_sampler_if;
  logic [6:0]  daddr_out;
  logic        den_out;
  logic        dwe_out;
  logic [15:0] di_out;
  logic        drdy_in;
  logic [15:0] do_in;

  modport master (
    output daddr_out, den_out, dwe_out, di_out,
    input  drdy_in, do_in
  );

  modport slave (
    input  daddr_out, den_out, dwe_out, di_out,
    output drdy_in, do_in
  );
endinterface

// File: rtl/xadc_drp_sampler.sv
// XADC DRP read controller with a 2**AVG_LOG2 boxcar averager, all on sysclk.
// Optional ground clamp of the averaged value: define XADC_SAMPLER_ZERO_CLAMP_EN.
module xadc_drp_sampler #(
  parameter logic [6:0]  ADDR_CH0    = 7'h14,
  parameter logic [6:0]  ADDR_CH1    = 7'h1C,
  parameter int          AVG_LOG2    = 4,
  parameter int          TIMEOUT_CYC = 64,
  parameter logic [11:0] CLAMP_LEVEL = 12'h00F
) (
  input  logic                      sysclk,
  input  logic                      rst_n,
  input  logic                      eoc_in,
  input  logic                      ch_sel,
  xadc_drp_sampler_if.master        drp,
  output logic [11:0]               sample_out,
  output logic                      sample_valid,
  output logic                      sample_ch,
  output logic                      timeout_err
);

  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] WIN_LEN  = CNT_W'(2 ** AVG_LOG2);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
`ifdef XADC_SAMPLER_ZERO_CLAMP_EN
  localparam bit CLAMP_ON = 1'b1;
`else
  localparam bit CLAMP_ON = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               cur_ch_q, cur_ch_d;
  logic [6:0]         daddr_q, daddr_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [11:0]        sample_q, sample_d;
  logic               sch_q, sch_d;
  logic               svld_q, svld_d;

  logic [ACC_W-1:0]   acc_sum;
  logic [CNT_W-1:0]   cnt_inc;
  logic [11:0]        avg;
  logic [11:0]        avg_out;
  logic               win_full;
  logic               tmr_expired;

  assign acc_sum     = acc_q + ACC_W'(drp.do_in[15:4]);
  assign cnt_inc     = cnt_q + 1'b1;
  assign win_full    = (cnt_inc == WIN_LEN);
  assign tmr_expired = (tmr_q == TMR_LAST);
  assign avg         = 12'(acc_sum >> AVG_LOG2);
  assign avg_out     = (CLAMP_ON && (avg <= CLAMP_LEVEL)) ? 12'h000 : avg;

  // State register
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (eoc_in) state_d = S_REQ;
      S_REQ:  state_d = S_WAIT;
      S_WAIT: begin
        if (drp.drdy_in)      state_d = win_full ? S_DONE : S_IDLE;
        else if (tmr_expired) state_d = S_IDLE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    drp.den_out = (state_q == S_REQ);
    timeout_err = (state_q == S_WAIT) && !drp.drdy_in && tmr_expired;
  end

  // The result is registered on the drdy that completes the window, so the
  // valid pulse during DONE sees sample_out already updated.
  always_comb begin
    cur_ch_d = cur_ch_q;
    daddr_d  = daddr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    sample_d = sample_q;
    sch_d    = sch_q;
    svld_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (eoc_in) begin
          cur_ch_d = ch_sel;
          daddr_d  = ch_sel ? ADDR_CH1 : ADDR_CH0;
          if (ch_sel != cur_ch_q) begin
            acc_d = '0;
            cnt_d = '0;
          end
        end
      end
      S_REQ: tmr_d = '0;
      S_WAIT: begin
        if (drp.drdy_in) begin
          acc_d = acc_sum;
          cnt_d = cnt_inc;
          if (win_full) begin
            sample_d = avg_out;
            sch_d    = cur_ch_q;
            svld_d   = 1'b1;
          end
        end else if (!tmr_expired) begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_DONE: begin
        acc_d = '0;
        cnt_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch_q <= 1'b0;
      daddr_q  <= ADDR_CH0;
      acc_q    <= '0;
      cnt_q    <= '0;
      tmr_q    <= '0;
      sample_q <= 12'h000;
      sch_q    <= 1'b0;
      svld_q   <= 1'b0;
    end else begin
      cur_ch_q <= cur_ch_d;
      daddr_q  <= daddr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      sample_q <= sample_d;
      sch_q    <= sch_d;
      svld_q   <= svld_d;
    end
  end

  assign drp.daddr_out = daddr_q;
  assign drp.dwe_out   = 1'b0;
  assign drp.di_out    = 16'h0000;
  assign sample_out    = sample_q;
  assign sample_ch     = sch_q;
  assign sample_valid  = svld_q;

endmodule

// File: tb/tb_xadc_drp_sampler.sv
// Directed plus randomized bench for xadc_drp_sampler with a queue-based window model.
module tb_xadc_drp_sampler;

  logic        sysclk = 1'b0;
  logic        rst_n;
  logic        eoc, ch_sel;
  logic [11:0] sample_out;
  logic        sample_valid, sample_ch, timeout_err;

  logic        eoc2;
  logic [11:0] s2_out;
  logic        s2_valid, s2_ch, s2_tmo;

  xadc_drp_sampler_if drp();
  xadc_drp_sampler_if drp2();

  xadc_drp_sampler #(.AVG_LOG2(2), .TIMEOUT_CYC(64)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .eoc_in(eoc), .ch_sel(ch_sel), .drp(drp.master),
    .sample_out(sample_out), .sample_valid(sample_valid), .sample_ch(sample_ch),
    .timeout_err(timeout_err)
  );

  xadc_drp_sampler #(.AVG_LOG2(0)) dut2 (
    .sysclk(sysclk), .rst_n(rst_n), .eoc_in(eoc2), .ch_sel(1'b0), .drp(drp2.master),
    .sample_out(s2_out), .sample_valid(s2_valid), .sample_ch(s2_ch),
    .timeout_err(s2_tmo)
  );

  always #5 sysclk = ~sysclk;

  int n_tests = 0;
  int n_fail  = 0;
  int vcnt    = 0;

  always @(posedge sysclk) if (sample_valid) vcnt++;

  // Reference model: values of the current window, its channel, last emitted sample
  int          m_vals[$];
  bit          m_ch;
  logic [11:0] m_last;
  bit          m_last_ch;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_vals.delete();
    m_ch      = 1'b0;
    m_last    = 12'h000;
    m_last_ch = 1'b0;
  endtask

  task automatic do_read(input bit ch, input logic [15:0] d, input int dly, input bit tmo);
    int v0, k, sum;
    bit exp_v;
    eoc = 1'b1; ch_sel = ch;
    @(negedge sysclk);
    eoc = 1'b0; ch_sel = 1'($urandom);
    check("den_after_eoc", drp.den_out, 1);
    check("daddr", drp.daddr_out, ch ? 7'h1C : 7'h14);
    if (ch != m_ch) m_vals.delete();
    m_ch = ch;
    v0 = vcnt;
    if (tmo) begin
      k = 0;
      do begin @(negedge sysclk); k++; end while (!timeout_err && k < 200);
      check("timeout_latency", k, 64);
      @(negedge sysclk);
      check("timeout_no_valid", vcnt - v0, 0);
    end else begin
      @(negedge sysclk);
      check("den_one_cycle", drp.den_out, 0);
      repeat (dly - 1) @(negedge sysclk);
      drp.drdy_in = 1'b1; drp.do_in = d;
      m_vals.push_back(int'(d[15:4]));
      exp_v = (m_vals.size() == 4);
      if (exp_v) begin
        sum = 0;
        foreach (m_vals[i]) sum += m_vals[i];
        m_last = 12'(sum / 4);
        m_last_ch = ch;
        m_vals.delete();
      end
      @(negedge sysclk);
      drp.drdy_in = 1'b0; drp.do_in = 16'($urandom);
      check("valid", sample_valid, exp_v);
      check("sample_out", sample_out, m_last);
      if (exp_v) check("sample_ch", sample_ch, m_last_ch);
      @(negedge sysclk);
      check("valid_count", vcnt - v0, exp_v);
    end
  endtask

  task automatic read2(input logic [15:0] d);
    logic [11:0] exp;
`ifdef XADC_SAMPLER_ZERO_CLAMP_EN
    exp = (d[15:4] <= 12'h00F) ? 12'h000 : d[15:4];
`else
    exp = d[15:4];
`endif
    eoc2 = 1'b1;
    @(negedge sysclk);
    eoc2 = 1'b0;
    check("clamp_den", drp2.den_out, 1);
    @(negedge sysclk);
    drp2.drdy_in = 1'b1; drp2.do_in = d;
    @(negedge sysclk);
    drp2.drdy_in = 1'b0;
    check("clamp_valid", s2_valid, 1);
    check("clamp_sample", s2_out, exp);
    @(negedge sysclk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v0, cyc, last_den, n_den, n_drdy, drdy_at;
    bit ch;
    rst_n = 1'b0; eoc = 1'b0; ch_sel = 1'b0; eoc2 = 1'b0;
    drp.drdy_in = 1'b0; drp.do_in = 16'h0;
    drp2.drdy_in = 1'b0; drp2.do_in = 16'h0;
    model_reset();
    repeat (3) @(negedge sysclk);
    check("rst_daddr", drp.daddr_out, 7'h14);
    check("rst_den", drp.den_out, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_sample", sample_out, 12'h000);
    check("rst_ch", sample_ch, 0);
    check("rst_tmo", timeout_err, 0);
    check("rst_dwe_di", {drp.dwe_out, drp.di_out}, 17'h0);
    rst_n = 1'b1;
    @(negedge sysclk);

    // Averaging window of four on ch0
    do_read(0, 16'h1000, 1, 0);
    do_read(0, 16'h2000, 2, 0);
    do_read(0, 16'h3000, 3, 0);
    do_read(0, 16'h4000, 1, 0);
    check("avg_value", sample_out, 12'h280);
    check("avg_ch", sample_ch, 0);

    // Channel switch discards partial ch0 window
    do_read(0, 16'h5550, 1, 0);
    do_read(0, 16'h5550, 2, 0);
    for (int i = 0; i < 4; i++) do_read(1, 16'hFFF0, 1 + i, 0);
    check("chsw_value", sample_out, 12'hFFF);
    check("chsw_ch", sample_ch, 1);

    // Timeout, then next eoc accepted normally
    do_read(1, 16'h0, 1, 1);
    do_read(1, 16'h1230, 2, 0);

    // Randomized reads
    ch = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) ch = ~ch;
      do_read(ch, 16'($urandom), int'($urandom_range(1, 6)), ($urandom_range(0, 7) == 0));
    end

    // Reset in the middle of a ch1 read
    eoc = 1'b1; ch_sel = 1'b1;
    @(negedge sysclk);
    eoc = 1'b0;
    check("pre_rst_den", drp.den_out, 1);
    repeat (2) @(negedge sysclk);
    v0 = vcnt;
    rst_n = 1'b0;
    #1;
    check("midrst_daddr", drp.daddr_out, 7'h14);
    check("midrst_den", drp.den_out, 0);
    check("midrst_sample", sample_out, 12'h000);
    check("midrst_valid_ch_tmo", {sample_valid, sample_ch, timeout_err}, 3'b000);
    @(negedge sysclk);
    rst_n = 1'b1;
    model_reset();
    drp.drdy_in = 1'b1; drp.do_in = 16'hFFF0;
    @(negedge sysclk);
    drp.drdy_in = 1'b0;
    repeat (3) @(negedge sysclk);
    check("midrst_no_valid", vcnt - v0, 0);
    do_read(0, 16'h0100, 1, 0);

    // eoc held high: one den per read, drdy 3 cycles after den
    ch_sel = 1'b0; eoc = 1'b1;
    cyc = 0; last_den = -1; n_den = 0; n_drdy = 0; drdy_at = -1;
    repeat (80) begin
      @(negedge sysclk);
      cyc++;
      drp.drdy_in = 1'b0;
      if (drp.den_out) begin
        if (last_den >= 0) check("den_gap", ((cyc - last_den) == 5) || ((cyc - last_den) == 6), 1);
        last_den = cyc;
        drdy_at = cyc + 3;
        n_den++;
      end
      if (cyc == drdy_at) begin
        drp.drdy_in = 1'b1; drp.do_in = 16'($urandom);
        n_drdy++;
      end
    end
    eoc = 1'b0;
    @(negedge sysclk);
    drp.drdy_in = 1'b0;
    check("eoc_hold_den_count_min", n_den >= 12, 1);
    check("eoc_hold_den_vs_drdy", n_den - n_drdy, (drdy_at > cyc) ? 1 : 0);
    repeat (8) @(negedge sysclk);

    // Clamp behaviour on the pass-through instance
    read2(16'h00A0);
    read2(16'h00F0);
    read2(16'h0100);
    read2(16'h1230);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
